// File: rtl/i2c_frame_rx_pkg.sv
// Shared types and constants for the I2C command-frame receiver.
// The command word is {6'b0, op[1:0], operand_a, operand_b, ans}, first byte on the wire in the top bits.
package i2c_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } rx_state_t;

  localparam int FRAME_W = 104;

  localparam int OP_LSB  = 96;
  localparam int A_LSB   = 64;
  localparam int B_LSB   = 32;
  localparam int ANS_LSB = 0;

  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b00;

  function automatic logic [FRAME_W-1:0] pack_cmd(input logic [1:0]  op,
                                                  input logic [31:0] a,
                                                  input logic [31:0] b,
                                                  input logic [31:0] ans);
    logic [FRAME_W-1:0] w;
    w = '0;
    w[OP_LSB +: 2]   = op;
    w[A_LSB +: 32]   = a;
    w[B_LSB +: 32]   = b;
    w[ANS_LSB +: 32] = ans;
    return w;
  endfunction

endpackage

// File: rtl/i2c_frame_rx_if.sv
// Downstream-facing side of the frame receiver: assembled word, strobe, status and error flags.
// The receiver is the slave side; the consumer (fpga_b_top or a bench) is the master side.
interface i2c_frame_rx_if;
  import i2c_frame_pkg::*;

  logic [FRAME_W-1:0] i2c_in;
  logic               frame_valid;
  logic               busy;
  logic               err_short;
  logic               err_overflow;
  logic               err_clr;

  modport slave (
    output i2c_in, frame_valid, busy, err_short, err_overflow,
    input  err_clr
  );

  modport master (
    input  i2c_in, frame_valid, busy, err_short, err_overflow,
    output err_clr
  );

endinterface

// File: rtl/i2c_frame_rx_edge_sync.sv
// Brings scl/sda into the clk domain and derives one-cycle scl edge and START/STOP pulses.
// Sync flops reset to 1 so an idle bus after reset never looks like a START.
module i2c_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_s;
  logic                   scl_prev;
  logic                   sda_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s = scl_pipe[SYNC_STAGES-1];
  assign sda_s = sda_pipe[SYNC_STAGES-1];

  // START/STOP need scl high on both samples so an sda change during the scl edge is not misread.
  assign scl_rise  =  scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s &  scl_prev;
  assign start_det =  scl_s &  scl_prev &  sda_prev & ~sda_s;
  assign stop_det  =  scl_s &  scl_prev & ~sda_prev &  sda_s;

endmodule

// File: rtl/i2c_frame_rx.sv
// Write-only I2C slave that collects FRAME_BYTES data bytes into one command word.
// The output word only changes on a complete, unpoisoned, STOP-terminated frame.
module i2c_frame_rx
  import i2c_frame_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         FRAME_BYTES = 13,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scl,
  inout  wire                sda,
  i2c_frame_rx_if.slave      bus
);

  localparam int                CNT_W = $clog2(FRAME_BYTES + 1);
  localparam int                BUF_W = 8 * FRAME_BYTES;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(FRAME_BYTES);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  rx_state_t        state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [CNT_W-1:0] byte_cnt, byte_cnt_n;
  logic [BUF_W-1:0] frame_buf, frame_buf_n;
  logic [BUF_W-1:0] i2c_in_q, i2c_in_n;
  logic             poison, poison_n;
  logic             ack_en, ack_en_n;
  logic             ack_phase, ack_phase_n;
  logic             sda_oe, sda_oe_n;
  logic             busy_q, busy_n;
  logic             frame_valid_q, frame_valid_n;
  logic             err_short_q, err_short_n;
  logic             err_ovf_q, err_ovf_n;
  logic             short_set, ovf_set;
  logic [7:0]       rx_byte;

  i2c_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign rx_byte = {shift[6:0], sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      byte_cnt      <= '0;
      frame_buf     <= '0;
      i2c_in_q      <= '0;
      poison        <= 1'b0;
      ack_en        <= 1'b0;
      ack_phase     <= 1'b0;
      sda_oe        <= 1'b0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      err_short_q   <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      shift         <= shift_n;
      byte_cnt      <= byte_cnt_n;
      frame_buf     <= frame_buf_n;
      i2c_in_q      <= i2c_in_n;
      poison        <= poison_n;
      ack_en        <= ack_en_n;
      ack_phase     <= ack_phase_n;
      sda_oe        <= sda_oe_n;
      busy_q        <= busy_n;
      frame_valid_q <= frame_valid_n;
      err_short_q   <= err_short_n;
      err_ovf_q     <= err_ovf_n;
    end
  end

  // STOP and START pre-empt whatever state we are in, including a half-shifted byte.
  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    byte_cnt_n    = byte_cnt;
    frame_buf_n   = frame_buf;
    i2c_in_n      = i2c_in_q;
    poison_n      = poison;
    ack_en_n      = ack_en;
    ack_phase_n   = ack_phase;
    sda_oe_n      = sda_oe;
    busy_n        = busy_q;
    frame_valid_n = 1'b0;
    short_set     = 1'b0;
    ovf_set       = 1'b0;

    if (stop_det || start_det) begin
      state_n     = stop_det ? IDLE : ADDR;
      bit_cnt_n   = '0;
      shift_n     = '0;
      byte_cnt_n  = '0;
      frame_buf_n = '0;
      poison_n    = 1'b0;
      ack_phase_n = 1'b0;
      sda_oe_n    = 1'b0;
      busy_n      = 1'b0;
      if (stop_det) begin
        if (byte_cnt == FULL && !poison) begin
          i2c_in_n      = frame_buf;
          frame_valid_n = 1'b1;
        end else if (byte_cnt != '0 && byte_cnt < FULL) begin
          short_set = 1'b1;
        end
      end
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == SLAVE_ADDR && !rx_byte[0]) begin
                state_n     = ADDR_ACK;
                ack_en_n    = 1'b1;
                ack_phase_n = 1'b0;
                byte_cnt_n  = '0;
                busy_n      = 1'b1;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end

        DATA: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_n     = DATA_ACK;
              ack_phase_n = 1'b0;
              if (byte_cnt < FULL) begin
                frame_buf_n = {frame_buf[BUF_W-9:0], rx_byte};
                byte_cnt_n  = byte_cnt + 1'b1;
                ack_en_n    = 1'b1;
              end else begin
                ovf_set  = 1'b1;
                poison_n = 1'b1;
                ack_en_n = 1'b0;
              end
            end
          end
        end

        // First scl fall after the 8th bit starts the ack slot, the next one ends it.
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase_n = 1'b1;
              sda_oe_n    = ack_en;
            end else begin
              ack_phase_n = 1'b0;
              sda_oe_n    = 1'b0;
              bit_cnt_n   = '0;
              state_n     = DATA;
            end
          end
        end

        default: begin
        end
      endcase
    end

    err_short_n = (err_short_q & ~bus.err_clr) | short_set;
    err_ovf_n   = (err_ovf_q   & ~bus.err_clr) | ovf_set;
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign bus.i2c_in       = i2c_in_q;
  assign bus.frame_valid  = frame_valid_q;
  assign bus.busy         = busy_q;
  assign bus.err_short    = err_short_q;
  assign bus.err_overflow = err_ovf_q;

endmodule

// File: tb/tb_i2c_frame_rx.sv
// Bench for i2c_frame_rx: bit-banged I2C master, frame-level reference model and a frame_valid scoreboard.
module tb_i2c_frame_rx;
  import i2c_frame_pkg::*;

  localparam logic [6:0] SLAVE_ADDR  = 7'h42;
  localparam int         FRAME_BYTES = 13;
  localparam int         Q           = 50;

  logic clk;
  logic rst;
  logic m_scl;
  logic m_sda;
  wire  sda;

  pullup (sda);
  assign sda = m_sda ? 1'bz : 1'b0;

  i2c_frame_rx_if bus ();

  i2c_frame_rx #(
    .SLAVE_ADDR  (SLAVE_ADDR),
    .FRAME_BYTES (FRAME_BYTES),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .scl (m_scl),
    .sda (sda),
    .bus (bus)
  );

  int                 checks;
  int                 errors;
  int                 busy_cnt;
  logic               fv_prev;
  logic [FRAME_W-1:0] sb_q[$];
  logic [FRAME_W-1:0] exp_i2c_in;
  logic               exp_short;
  logic               exp_ovf;
  logic [7:0]         tx[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [FRAME_W-1:0] act,
                             input logic [FRAME_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst) begin
      fv_prev = 1'b0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (fv_prev) checkOutput("fv_one_cycle", bus.frame_valid, 0);
      if (bus.frame_valid) begin
        if (sb_q.size() == 0) checkOutput("fv_unexpected", bus.frame_valid, 0);
        else                  checkOutput("frame_data", bus.i2c_in, sb_q.pop_front());
      end
      fv_prev = bus.frame_valid;
    end
  end

  task automatic busStart();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic busStop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
    #Q;
  endtask

  task automatic writeBit(input logic b);
    m_sda = b;    #Q;
    m_scl = 1'b1; #(2*Q);
    m_scl = 1'b0; #Q;
  endtask

  task automatic writeByte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) writeBit(b[i]);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    acked = (sda === 1'b0);
    #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic loadWord(input logic [FRAME_W-1:0] w);
    tx.delete();
    for (int i = 0; i < FRAME_BYTES; i++) tx.push_back(w[FRAME_W-1-8*i -: 8]);
  endtask

  task automatic clearErrors();
    @(negedge clk) bus.err_clr = 1'b1;
    @(negedge clk) bus.err_clr = 1'b0;
    exp_short = 1'b0;
    exp_ovf   = 1'b0;
    @(negedge clk);
    checkOutput("clr_err_short", bus.err_short, exp_short);
    checkOutput("clr_err_overflow", bus.err_overflow, exp_ovf);
  endtask

  // One write transaction from START; the model decides ACKs and the frame outcome from the byte list.
  task automatic applyStimulus(input logic [6:0] addr, input logic rw, input bit end_stop,
                               input string tag);
    logic               acked;
    logic               addr_ok;
    logic [FRAME_W-1:0] frame;
    int                 n;
    int                 busy_start;
    n          = tx.size();
    addr_ok    = (addr == SLAVE_ADDR) && !rw;
    busy_start = busy_cnt;
    frame      = '0;
    busStart();
    writeByte({addr, rw}, acked);
    checkOutput($sformatf("%s_addr_ack", tag), acked, addr_ok);
    checkOutput($sformatf("%s_busy", tag), bus.busy, addr_ok);
    for (int i = 0; i < n; i++) begin
      writeByte(tx[i], acked);
      checkOutput($sformatf("%s_ack%0d", tag, i), acked, addr_ok && (i < FRAME_BYTES));
      if (i < FRAME_BYTES) frame = {frame[FRAME_W-9:0], tx[i]};
    end
    if (addr_ok && n > FRAME_BYTES) exp_ovf = 1'b1;
    if (end_stop) begin
      if (addr_ok && n == FRAME_BYTES) begin
        sb_q.push_back(frame);
        exp_i2c_in = frame;
      end else if (addr_ok && n > 0 && n < FRAME_BYTES) begin
        exp_short = 1'b1;
      end
      busStop();
      repeat (4) @(negedge clk);
      checkOutput($sformatf("%s_busy_end", tag), bus.busy, 0);
      checkOutput($sformatf("%s_frame_pending", tag), sb_q.size(), 0);
      checkOutput($sformatf("%s_i2c_in", tag), bus.i2c_in, exp_i2c_in);
    end
    checkOutput($sformatf("%s_err_short", tag), bus.err_short, exp_short);
    checkOutput($sformatf("%s_err_overflow", tag), bus.err_overflow, exp_ovf);
    if (!addr_ok) checkOutput($sformatf("%s_busy_never", tag), busy_cnt - busy_start, 0);
  endtask

  initial begin
    logic               acked;
    logic [FRAME_W-1:0] w;
    checks      = 0;
    errors      = 0;
    busy_cnt    = 0;
    fv_prev     = 1'b0;
    exp_i2c_in  = '0;
    exp_short   = 1'b0;
    exp_ovf     = 1'b0;
    m_scl       = 1'b1;
    m_sda       = 1'b1;
    bus.err_clr = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("rst_i2c_in", bus.i2c_in, 0);
    checkOutput("rst_frame_valid", bus.frame_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_err_short", bus.err_short, 0);
    checkOutput("rst_err_overflow", bus.err_overflow, 0);
    checkOutput("rst_sda", sda, 1);

    tx = '{8'h00, 8'h40, 8'h40, 8'h00, 8'h00, 8'h40, 8'h40, 8'h00,
           8'h00, 8'h40, 8'h40, 8'h00, 8'h00};
    applyStimulus(7'h42, 1'b0, 1'b1, "tp1");
    checkOutput("tp1_word", bus.i2c_in, 104'h00_40400000_40400000_40400000);

    applyStimulus(7'h43, 1'b0, 1'b1, "tp2");

    loadWord(pack_cmd(OP_MUL, 32'h3F000000, 32'h3F000000, 32'h40400000));
    applyStimulus(SLAVE_ADDR, 1'b0, 1'b1, "tp3a");
    tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus(SLAVE_ADDR, 1'b0, 1'b1, "tp3b");
    checkOutput("tp3_err_short_set", bus.err_short, 1);
    clearErrors();

    tx.delete();
    for (int i = 0; i < FRAME_BYTES + 1; i++) tx.push_back(8'($urandom));
    applyStimulus(SLAVE_ADDR, 1'b0, 1'b1, "tp4");
    checkOutput("tp4_err_ovf_set", bus.err_overflow, 1);
    clearErrors();

    tx.delete();
    for (int i = 0; i < 6; i++) tx.push_back(8'($urandom));
    applyStimulus(SLAVE_ADDR, 1'b0, 1'b0, "tp5a");
    loadWord(pack_cmd(OP_NOP, $urandom, $urandom, $urandom));
    applyStimulus(SLAVE_ADDR, 1'b0, 1'b1, "tp5b");
    checkOutput("tp5_op", bus.i2c_in[OP_LSB +: 2], 2'b00);

    // Reset lands while the slave is holding sda low in the address ACK slot.
    busStart();
    for (int i = 7; i >= 0; i--) writeBit(i == 0 ? 1'b0 : SLAVE_ADDR[i-1]);
    m_sda = 1'b1;
    checkOutput("tp6_ack_drive", sda, 0);
    rst = 1'b1;
    #1;
    checkOutput("tp6_sda_release", sda, 1);
    checkOutput("tp6_i2c_in", bus.i2c_in, 0);
    checkOutput("tp6_busy", bus.busy, 0);
    checkOutput("tp6_frame_valid", bus.frame_valid, 0);
    checkOutput("tp6_err_short", bus.err_short, 0);
    checkOutput("tp6_err_overflow", bus.err_overflow, 0);
    exp_i2c_in = '0;
    exp_short  = 1'b0;
    exp_ovf    = 1'b0;
    sb_q.delete();
    #(Q-1);
    m_scl = 1'b1; #Q;
    m_scl = 1'b0; #Q;
    @(negedge clk) rst = 1'b0;
    busStop();
    w = pack_cmd(OP_MUL, $urandom, $urandom, $urandom);
    loadWord(w);
    applyStimulus(SLAVE_ADDR, 1'b0, 1'b1, "tp6");
    checkOutput("tp6_word", bus.i2c_in, w);

    for (int t = 0; t < 8; t++) begin
      logic [6:0] a;
      logic       rw;
      int         n;
      bit         st;
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
      rw = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0:       n = $urandom_range(0, FRAME_BYTES - 1);
        1:       n = FRAME_BYTES + 1;
        default: n = FRAME_BYTES;
      endcase
      st = (t == 7) || ($urandom_range(0, 4) != 0);
      tx.delete();
      for (int i = 0; i < n; i++) tx.push_back(8'($urandom));
      applyStimulus(a, rw, st, $sformatf("rnd%0d", t));
      if ($urandom_range(0, 2) == 0) clearErrors();
    end

    repeat (10) @(negedge clk);
    checkOutput("end_frames_pending", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_frame_rx.md
Name: i2c_frame_rx

Overview:
- Write-only I2C slave that sits directly upstream of fpga_b_top.
- Assembles 13 received bytes into the 104-bit command word {6'b0, op[1:0], operand_a[31:0], operand_b[31:0], ans[31:0]}.
- Presents that word as i2c_in to fpga_b_top.
- Only complete, STOP-terminated frames update the output, so the multiplier and OLED path never see a partial word.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit I2C address the block responds to.
- FRAME_BYTES, 13, data bytes per frame; output width is 8*FRAME_BYTES.
- SYNC_STAGES, 2, flip-flop synchroniser depth on scl and sda.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- scl  input  1  I2C clock from master; slave never stretches the clock.
- sda  inout  1  I2C data; open-drain, driven only to 0, otherwise 'z'.
- i2c_in  output  104  last complete frame; first received byte goes to [103:96].
- frame_valid  output  1  one-cycle pulse when i2c_in updates.
- busy  output  1  high from address-match ACK until STOP or repeated START.
- err_short  output  1  sticky; frame ended with fewer than FRAME_BYTES bytes.
- err_overflow  output  1  sticky; master sent more than FRAME_BYTES bytes.
- err_clr  input  1  synchronous clear of both sticky error flags.

Behaviour:
- Reset (async, any state): i2c_in=0, frame_valid=0, busy=0, err_*=0, sda released (z), FSM=IDLE, byte counter=0, partial shift buffer=0. Release is effective in the same cycle reset asserts.
- Synchronisation: scl and sda each pass through SYNC_STAGES flops plus one history flop.
- Edge and condition detection uses the synchronised values only:
  - START = sda 1->0 while scl=1.
  - STOP = sda 0->1 while scl=1.
  - Data is sampled on scl rising edge.
  - sda is changed only on scl falling edge.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: START -> ADDR; bit counter=0.
- ADDR: shift 8 bits MSB first. On the 8th rising edge:
  - addr==SLAVE_ADDR and R/W=0 -> ADDR_ACK.
  - otherwise -> IGNORE (NACK; sda stays released).
- ADDR_ACK: pull sda low from the next scl falling edge to the following scl falling edge. Clear byte counter, assert busy, then -> DATA.
- DATA: shift 8 bits into the byte at index = byte counter. On the 8th rising edge:
  - if byte counter < FRAME_BYTES: store the byte, increment counter, -> DATA_ACK (ACK).
  - else: set err_overflow, mark frame poisoned, -> DATA_ACK with NACK (sda released).
- DATA_ACK: same ACK timing as ADDR_ACK, then -> DATA.
- IGNORE: sda released; wait for START or STOP.
- STOP in any state -> IDLE, busy=0:
  - counter==FRAME_BYTES and not poisoned: copy buffer to i2c_in and pulse frame_valid on the cycle after STOP is detected (3 clk after the pin change with SYNC_STAGES=2).
  - 0 < counter < FRAME_BYTES: set err_short; i2c_in unchanged.
  - counter==0 (address-only write): no error, no update.
- Repeated START in any state: discard the partial buffer without raising an error, -> ADDR.
- STOP or START seen mid-byte: abort the byte, then apply the STOP / repeated-START rules above.
- i2c_in holds its value indefinitely between frames. frame_valid is never high for two consecutive cycles.
- err_clr and an error event in the same cycle: the error event wins (flag ends set).
- Supports 100 kHz and 400 kHz I2C; the clk/scl ratio must be >= 16.

Decomposition:
- Package i2c_frame_pkg holds:
  - state enum;
  - FRAME_W=104;
  - field offsets OP_LSB=96, A_LSB=64, B_LSB=32, ANS_LSB=0;
  - op codes OP_MUL=2'b10, OP_NOP=2'b00.
- One sub-module, i2c_edge_sync: synchroniser plus scl_rise, scl_fall, start_det and stop_det pulse generation.

Test Plan:
- Addr 0x42 write, 13 bytes 00 40 40 00 00 40 40 00 00 40 40 00 00, STOP -> 14 ACKs; i2c_in=0x00_40400000_40400000_40400000, frame_valid exactly 1 cycle, busy falls at STOP.
- Addr 0x43 write, 13 bytes -> address NACK, all data bits ignored, no frame_valid, i2c_in unchanged, busy never high.
- Valid frame (op=10, 3F000000, 3F000000, 40400000), then a 5-byte frame with STOP -> err_short=1, no second frame_valid, i2c_in still holds the first frame; err_clr -> err_short=0.
- 14 data bytes then STOP -> 14th byte NACKed, err_overflow=1, no frame_valid, i2c_in unchanged.
- 6 bytes, repeated START, then a full 13-byte frame (op=00) + STOP -> exactly one frame_valid, i2c_in[97:96]=2'b00, no error flags.
- Assert rst while sda is held low during an ACK -> sda released within the same cycle; all outputs 0. A subsequent full frame is received correctly.
